// File: rtl/data_ram_responder.sv
// Single-port word RAM behind a req/ack handshake with a fixed number of
// wait states. Requests are latched on acceptance, a down-counter sets the
// wait time, and the access completes in a one-cycle ACK state. Bad addresses
// (misaligned or beyond the memory depth) complete with err_o and no write.
//
//  state  | meaning
//  IDLE   | ready; accept and latch a request when req_i is high
//  WAIT   | wait states counting down; req_i low here aborts the access
//  ACK    | single completion cycle; write commits, read data is driven
module data_ram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   word_q, word_d;

  logic [31:0]         mem_q [2**ADDR_W];
  logic                addr_bad;
  logic                mem_we;

  // An address is unusable if it is not word aligned or points past the RAM.
  assign addr_bad = (addr_i[1:0] != 2'b00) || ((addr_i >> (ADDR_W + 2)) != 32'd0);

  // Next-state logic, request latching and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    sel_d   = sel_q;
    data_d  = data_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          err_d   = addr_bad;
          sel_d   = sel_i;
          data_d  = data_i;
          word_d  = addr_i[ADDR_W+1:2];
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          // requester gave up: drop the access without touching memory
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched request registers; memory is deliberately not reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 4'd0;
      data_q  <= 32'd0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      word_q  <= word_d;
    end
  end

  assign mem_we = (state_q == S_ACK) && we_q && !err_q;

  // Byte-lane write, committed at the end of the ACK cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) begin
          mem_q[word_q][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    ack_o  = (state_q == S_ACK);
    err_o  = ack_o && err_q;
    busy_o = (state_q != S_IDLE);
    data_o = 32'd0;
    if (ack_o && !err_q && !we_q) begin
      data_o = mem_q[word_q];
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: random and directed transactions against a
// word-array reference model, with a scoreboard monitor checking every ack.
module tb_data_ram_responder;

  localparam int ADDR_W = 10;
  localparam int W      = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic [31:0] addr_i, data_i;
  logic [3:0]  sel_i;
  logic [31:0] data_o;
  logic        ack_o, err_o, busy_o;

  logic        req0, we0;
  logic [31:0] addr0, din0, dout0;
  logic [3:0]  sel0;
  logic        ack0, err0, busy0;

  data_ram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .ack_o(ack_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  data_ram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .sel_i(sel0), .data_i(din0), .data_o(dout0), .ack_o(ack0),
    .err_o(err0), .busy_o(busy0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (64'(a) >= (64'd1 << (ADDR_W + 2)));
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 32'($urandom_range(0, 15) * 4);
    if (r == 7) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    if (r == 8) return 32'h1000 + 32'($urandom_range(0, 15) * 4);
    return $urandom | 32'h8000_0000;
  endfunction

  // Scoreboard monitor: every ack pops one expectation; idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (ack_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual ack_o=1 required ack_o=0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("ack_err", {31'b0, err_o}, {31'b0, e.err});
        chk("ack_data", data_o, e.data);
      end
    end else begin
      chk("idle_data", data_o, 32'd0);
      chk("idle_err", {31'b0, err_o}, 32'd0);
    end
  end

  // One complete transaction; called at a negedge with the DUT idle.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] data);
    exp_t e;
    logic err;
    int   idx;
    bit   got;
    chk("busy_before_req", {31'b0, busy_o}, 32'd0);
    err    = exp_err(addr);
    idx    = int'(addr >> 2) & 15;
    e.cyc  = cyc + 1 + W;
    e.err  = err;
    e.data = (!err && !we) ? mem_m[idx] : 32'd0;
    if (!err && we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
    end
    exp_q.push_back(e);
    req_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack_o) got = 1;
      else begin
        we_i = 1'($urandom); addr_i = $urandom; sel_i = 4'($urandom); data_i = $urandom;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout actual no_ack required ack (t=%0t)", $time);
      exp_q.delete();
    end
    req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic abort_write(input logic [31:0] addr, input logic [31:0] data);
    req_i = 1'b1; we_i = 1'b1; addr_i = addr; sel_i = 4'hF; data_i = data;
    @(negedge clk);
    chk("abort_busy_wait", {31'b0, busy_o}, 32'd1);
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    chk("abort_busy_fall", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
  endtask

  task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] data);
    req_i = 1'b1; we_i = 1'b1; addr_i = addr; sel_i = 4'hF; data_i = data;
    @(negedge clk);
    chk("rst_pre_busy", {31'b0, busy_o}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_mid_err", {31'b0, err_o}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_mid_data", data_o, 32'd0);
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_i = 0; we_i = 0; addr_i = 0; sel_i = 0; data_i = 0;
    req0 = 0; we0 = 0; addr0 = 0; sel0 = 0; din0 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ack", {31'b0, ack_o}, 32'd0);
    chk("reset_err", {31'b0, err_o}, 32'd0);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_data", data_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 16; w++) txn(1'b1, 32'(w * 4), 4'hF, $urandom);

    txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 4'h0, 32'h0);
    txn(1'b1, 32'h10, 4'b0010, 32'h0000AA00);
    txn(1'b0, 32'h10, 4'hF, 32'h0);
    txn(1'b0, 32'h13, 4'hF, 32'h0);
    txn(1'b0, 32'h1000, 4'hF, 32'h0);
    txn(1'b1, 32'h1010, 4'hF, 32'h55555555);
    txn(1'b0, 32'h10, 4'h0, 32'h0);

    abort_write(32'h10, 32'h11111111);
    txn(1'b0, 32'h10, 4'hF, 32'h0);

    reset_mid_write(32'h20, 32'h22222222);
    txn(1'b0, 32'h20, 4'hF, 32'h0);

    for (int n = 0; n < 300; n++) begin
      txn(1'($urandom), rand_addr(), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    for (int w = 0; w < 16; w++) txn(1'b0, 32'(w * 4), 4'hF, 32'h0);

    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; sel0 = 4'hF; din0 = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("w0_ack_pattern", {31'b0, ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    we0 = 1'b0;
    @(negedge clk);
    chk("w0_read_ack", {31'b0, ack0}, 32'd1);
    chk("w0_read_err", {31'b0, err0}, 32'd0);
    chk("w0_read_data", dout0, 32'h12345678);
    req0 = 1'b0;
    @(negedge clk);
    chk("w0_busy_end", {31'b0, busy0}, 32'd0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
